// File: rtl/uart_defs_pkg.sv
// Shared types for the oversampling UART receiver: FSM states, per-frame config and word flags.
package uart_defs;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StParity,
    StStop1,
    StStop2,
    StBreak
  } RxState_t;

  typedef struct packed {
    logic [3:0] data_bits;
    logic       parity_en;
    logic       parity_odd;
    logic       stop2;
  } RxFrameCfg_t;

  typedef struct packed {
    logic frame_err;
    logic parity_err;
  } RxWordFlags_t;

  function automatic logic [3:0] clamp_data_bits(input logic [3:0]  req,
                                                 input int unsigned max_bits);
    if (req < 4'd5) return 4'd5;
    if (int'(req) > int'(max_bits)) return 4'(max_bits);
    return req;
  endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Synchronous first-word-fall-through FIFO; a push while full succeeds only alongside a pop.
module uart_sync_fifo #(
  parameter int unsigned WIDTH = 11,
  parameter int unsigned DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         wdata_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         rdata_o,
  output logic [$clog2(DEPTH):0]   level_o,
  output logic                     full_o,
  output logic                     empty_o
);
  localparam int unsigned AddrW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AddrW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AddrW:0]   level_q, level_d;
  logic             do_push, do_pop;

  assign full_o  = (level_q == (AddrW + 1)'(DEPTH));
  assign empty_o = (level_q == '0);
  assign level_o = level_q;
  assign rdata_o = empty_o ? '0 : mem_q[rd_ptr_q];

  always_comb begin
    do_pop   = pop_i & ~empty_o;
    do_push  = push_i & (~full_o | do_pop);
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = wdata_i;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (do_pop) rd_ptr_d = rd_ptr_q + 1'b1;
    level_d = level_q + (AddrW + 1)'(do_push) - (AddrW + 1)'(do_pop);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

endmodule

// File: rtl/uart_rx_os.sv
// Oversampling UART receiver: synchronizer, tick generator, framing FSM with majority-vote
// sampling, break/timeout detection and an RX FIFO with RTS flow control.
module uart_rx_os
  import uart_defs::*;
#(
  parameter int unsigned DATA_W       = 9,
  parameter int unsigned FIFO_DEPTH   = 16,
  parameter int unsigned OSR          = 16,
  parameter int unsigned DIV_W        = 16,
  parameter int unsigned TIMEOUT_BITS = 40
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            rx_i,
  input  logic                            enable_i,
  input  logic [DIV_W-1:0]                divider_i,
  input  logic [3:0]                      data_bits_i,
  input  logic                            parity_en_i,
  input  logic                            parity_odd_i,
  input  logic                            stop2_i,
  output logic [DATA_W-1:0]               rx_d_o,
  output logic [1:0]                      rx_flags_o,
  output logic                            rx_d_valid_o,
  input  logic                            rx_d_ready_i,
  output logic [$clog2(FIFO_DEPTH):0]     level_o,
  output logic                            full_o,
  output logic                            empty_o,
  output logic                            rts_n_o,
  output logic                            overrun_o,
  output logic                            break_o,
  output logic                            timeout_o,
  input  logic                            err_clr_i
);
  localparam int unsigned OsW   = $clog2(OSR);
  localparam int unsigned ToW   = $clog2(TIMEOUT_BITS + 1);
  localparam int unsigned LvlW  = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned WordW = DATA_W + 2;

  logic              sync1_q, sync2_q, rx_prev_q, rx_s;
  logic [DIV_W-1:0]  tick_cnt_q, tick_cnt_d;
  logic [OsW-1:0]    os_cnt_q, os_cnt_d;
  logic              s0_q, s0_d, s1_q, s1_d;
  RxState_t          state_q, state_d;
  RxFrameCfg_t       cfg_q, cfg_d;
  RxWordFlags_t      flags_q, flags_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [3:0]        bit_cnt_q, bit_cnt_d;
  logic              par_acc_q, par_acc_d, par_bit_q, par_bit_d;
  logic              push_q, push_d;
  logic [ToW-1:0]    to_cnt_q, to_cnt_d;
  logic              overrun_q, overrun_d, break_q, break_d, timeout_q, timeout_d;
  logic              rts_n_q, rts_n_d;
  logic              tick, bit_end, vote_now, vote, start_edge, pop, break_set, timeout_set;
  logic [WordW-1:0]  fifo_rdata;

  assign rx_s       = sync2_q;
  assign tick       = (tick_cnt_q == divider_i);
  assign bit_end    = tick & (os_cnt_q == OsW'(OSR - 1));
  assign vote_now   = tick & (os_cnt_q == OsW'(OSR / 2 + 1));
  assign vote       = (s0_q & s1_q) | (s0_q & rx_s) | (s1_q & rx_s);
  assign start_edge = (state_q == StIdle) & enable_i & rx_prev_q & ~rx_s;
  assign pop        = rx_d_valid_o & rx_d_ready_i;

  // Tick generator and oversample phase; both realign on a start edge.
  always_comb begin
    tick_cnt_d = tick ? '0 : tick_cnt_q + 1'b1;
    os_cnt_d   = os_cnt_q;
    if (tick) os_cnt_d = bit_end ? '0 : os_cnt_q + 1'b1;
    if (start_edge) begin
      tick_cnt_d = '0;
      os_cnt_d   = '0;
    end
    s0_d = s0_q;
    s1_d = s1_q;
    if (tick && os_cnt_q == OsW'(OSR / 2 - 1)) s0_d = rx_s;
    if (tick && os_cnt_q == OsW'(OSR / 2))     s1_d = rx_s;
  end

  always_comb begin
    state_d   = state_q;
    cfg_d     = cfg_q;
    flags_d   = flags_q;
    data_d    = data_q;
    bit_cnt_d = bit_cnt_q;
    par_acc_d = par_acc_q;
    par_bit_d = par_bit_q;
    push_d    = 1'b0;
    break_set = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start_edge) begin
          state_d   = StStart;
          cfg_d     = '{data_bits:  clamp_data_bits(data_bits_i, DATA_W),
                        parity_en:  parity_en_i,
                        parity_odd: parity_odd_i,
                        stop2:      stop2_i};
          flags_d   = '0;
          data_d    = '0;
          bit_cnt_d = '0;
          par_acc_d = 1'b0;
          par_bit_d = 1'b0;
        end
      end
      StStart: if (vote_now) state_d = vote ? StIdle : StData;
      StData: begin
        if (vote_now) begin
          data_d[bit_cnt_q] = vote;
          par_acc_d         = par_acc_q ^ vote;
          bit_cnt_d         = bit_cnt_q + 4'd1;
          if (bit_cnt_q == cfg_q.data_bits - 4'd1) begin
            state_d = cfg_q.parity_en ? StParity : StStop1;
          end
        end
      end
      StParity: begin
        if (vote_now) begin
          par_bit_d          = vote;
          flags_d.parity_err = ((par_acc_q ^ vote) != cfg_q.parity_odd);
          state_d            = StStop1;
        end
      end
      StStop1: begin
        if (vote_now) begin
          if (!vote && data_q == '0 && !par_bit_q) begin
            break_set = 1'b1;
            state_d   = StBreak;
          end else begin
            flags_d.frame_err = ~vote;
            if (cfg_q.stop2) begin
              state_d = StStop2;
            end else begin
              push_d  = 1'b1;
              state_d = StIdle;
            end
          end
        end
      end
      StStop2: begin
        if (vote_now) begin
          flags_d.frame_err = flags_q.frame_err | ~vote;
          push_d            = 1'b1;
          state_d           = StIdle;
        end
      end
      StBreak: if (rx_s) state_d = StIdle;
      default: state_d = StIdle;
    endcase
    if (!enable_i) state_d = StIdle;
  end

  // Idle timeout counts whole bit periods and saturates so it fires only once.
  always_comb begin
    to_cnt_d    = to_cnt_q;
    timeout_set = 1'b0;
    if (start_edge || pop) begin
      to_cnt_d = '0;
    end else if (state_q == StIdle && !empty_o && bit_end &&
                 to_cnt_q != ToW'(TIMEOUT_BITS)) begin
      to_cnt_d    = to_cnt_q + 1'b1;
      timeout_set = (to_cnt_d == ToW'(TIMEOUT_BITS));
    end
    overrun_d = (push_q & full_o & ~pop) | (overrun_q & ~err_clr_i);
    break_d   = break_set | (break_q & ~err_clr_i);
    timeout_d = timeout_set | (timeout_q & ~err_clr_i & ~start_edge & ~pop);
    rts_n_d   = ~enable_i | (level_o >= LvlW'(FIFO_DEPTH - 2));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q    <= 1'b1;
      sync2_q    <= 1'b1;
      rx_prev_q  <= 1'b1;
      tick_cnt_q <= '0;
      os_cnt_q   <= '0;
      s0_q       <= 1'b1;
      s1_q       <= 1'b1;
      state_q    <= StIdle;
      cfg_q      <= '0;
      flags_q    <= '0;
      data_q     <= '0;
      bit_cnt_q  <= '0;
      par_acc_q  <= 1'b0;
      par_bit_q  <= 1'b0;
      push_q     <= 1'b0;
      to_cnt_q   <= '0;
      overrun_q  <= 1'b0;
      break_q    <= 1'b0;
      timeout_q  <= 1'b0;
      rts_n_q    <= 1'b1;
    end else begin
      sync1_q    <= rx_i;
      sync2_q    <= sync1_q;
      rx_prev_q  <= sync2_q;
      tick_cnt_q <= tick_cnt_d;
      os_cnt_q   <= os_cnt_d;
      s0_q       <= s0_d;
      s1_q       <= s1_d;
      state_q    <= state_d;
      cfg_q      <= cfg_d;
      flags_q    <= flags_d;
      data_q     <= data_d;
      bit_cnt_q  <= bit_cnt_d;
      par_acc_q  <= par_acc_d;
      par_bit_q  <= par_bit_d;
      push_q     <= push_d;
      to_cnt_q   <= to_cnt_d;
      overrun_q  <= overrun_d;
      break_q    <= break_d;
      timeout_q  <= timeout_d;
      rts_n_q    <= rts_n_d;
    end
  end

  uart_sync_fifo #(
    .WIDTH (WordW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push_q),
    .wdata_i ({flags_q, data_q}),
    .pop_i   (rx_d_ready_i),
    .rdata_o (fifo_rdata),
    .level_o (level_o),
    .full_o  (full_o),
    .empty_o (empty_o)
  );

  assign rx_d_o       = fifo_rdata[DATA_W-1:0];
  assign rx_flags_o   = fifo_rdata[DATA_W+:2];
  assign rx_d_valid_o = ~empty_o;
  assign rts_n_o      = rts_n_q;
  assign overrun_o    = overrun_q;
  assign break_o      = break_q;
  assign timeout_o    = timeout_q;

endmodule

// File: tb/tb_uart_rx_os.sv
// Randomised and directed bench for uart_rx_os against a frame-level queue model.
module tb_uart_rx_os;
  localparam int unsigned DATA_W       = 9;
  localparam int unsigned FIFO_DEPTH   = 16;
  localparam int unsigned OSR          = 16;
  localparam int unsigned DIV_W        = 16;
  localparam int unsigned TIMEOUT_BITS = 40;
  localparam int unsigned LVL_W        = $clog2(FIFO_DEPTH) + 1;

  logic              clk = 1'b0;
  logic              rst, rx_i, enable_i, parity_en_i, parity_odd_i, stop2_i;
  logic [DIV_W-1:0]  divider_i;
  logic [3:0]        data_bits_i;
  logic [DATA_W-1:0] rx_d_o;
  logic [1:0]        rx_flags_o;
  logic              rx_d_valid_o, rx_d_ready_i, full_o, empty_o, rts_n_o;
  logic              overrun_o, break_o, timeout_o, err_clr_i;
  logic [LVL_W-1:0]  level_o;

  always #5 clk = ~clk;

  uart_rx_os #(
    .DATA_W       (DATA_W),
    .FIFO_DEPTH   (FIFO_DEPTH),
    .OSR          (OSR),
    .DIV_W        (DIV_W),
    .TIMEOUT_BITS (TIMEOUT_BITS)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .rx_i         (rx_i),
    .enable_i     (enable_i),
    .divider_i    (divider_i),
    .data_bits_i  (data_bits_i),
    .parity_en_i  (parity_en_i),
    .parity_odd_i (parity_odd_i),
    .stop2_i      (stop2_i),
    .rx_d_o       (rx_d_o),
    .rx_flags_o   (rx_flags_o),
    .rx_d_valid_o (rx_d_valid_o),
    .rx_d_ready_i (rx_d_ready_i),
    .level_o      (level_o),
    .full_o       (full_o),
    .empty_o      (empty_o),
    .rts_n_o      (rts_n_o),
    .overrun_o    (overrun_o),
    .break_o      (break_o),
    .timeout_o    (timeout_o),
    .err_clr_i    (err_clr_i)
  );

  int checks   = 0;
  int failures = 0;
  int bit_len  = OSR;
  logic [DATA_W+1:0] exp_q[$];
  logic              exp_ovr = 1'b0;

  task automatic idle_bits(input int n);
    rx_i = 1'b1;
    repeat (n * bit_len) @(negedge clk);
  endtask

  task automatic drive_bit(input logic b);
    rx_i = b;
    repeat (bit_len) @(negedge clk);
  endtask

  task automatic pulse_clr();
    err_clr_i = 1'b1;
    @(negedge clk);
    err_clr_i = 1'b0;
    @(negedge clk);
  endtask

  // Sends one frame on the line; optionally records the expected FIFO word in the model.
  task automatic send_frame(input logic [DATA_W-1:0] data, input int req_bits,
                            input logic par_en, input logic odd, input logic two_stop,
                            input logic bad_par, input logic bad_stop1,
                            input logic bad_stop2, input logic scramble, input logic model_en);
    int                nb;
    logic [DATA_W-1:0] mdata;
    logic              pbit, perr, ferr;
    nb    = (req_bits < 5) ? 5 : (req_bits > int'(DATA_W)) ? int'(DATA_W) : req_bits;
    mdata = '0;
    for (int i = 0; i < nb; i++) mdata[i] = data[i];
    pbit  = ($countones(mdata) % 2 == 1) ^ odd ^ bad_par;
    perr  = par_en && ((($countones(mdata) + int'(pbit)) % 2 == 1) != odd);
    ferr  = bad_stop1 | (two_stop & bad_stop2);
    data_bits_i  = req_bits[3:0];
    parity_en_i  = par_en;
    parity_odd_i = odd;
    stop2_i      = two_stop;
    drive_bit(1'b0);
    if (scramble) begin
      data_bits_i  = 4'($urandom);
      parity_en_i  = 1'($urandom);
      parity_odd_i = 1'($urandom);
      stop2_i      = 1'($urandom);
    end
    for (int i = 0; i < nb; i++) drive_bit(mdata[i]);
    if (par_en) drive_bit(pbit);
    drive_bit(~bad_stop1);
    if (two_stop) drive_bit(~bad_stop2);
    rx_i = 1'b1;
    if (model_en) begin
      if (exp_q.size() < FIFO_DEPTH) exp_q.push_back({ferr, perr, mdata});
      else exp_ovr = 1'b1;
    end
  endtask

  // Waits (bounded) for a head word, then pops it; ok=0 if none arrived.
  task automatic pop_word(output logic ok, output logic [DATA_W+1:0] word);
    int n = 0;
    while (!rx_d_valid_o && n < 8 * bit_len) begin
      @(negedge clk);
      n++;
    end
    ok   = rx_d_valid_o;
    word = {rx_flags_o, rx_d_o};
    rx_d_ready_i = 1'b1;
    @(negedge clk);
    rx_d_ready_i = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    rx_i = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (rx_d_valid_o !== 1'b0 || empty_o !== 1'b1 || full_o !== 1'b0) begin
      failures++;
      $display("FAIL reset_status valid=%b empty=%b full=%b need 0/1/0",
               rx_d_valid_o, empty_o, full_o);
    end
    checks++;
    if ({rx_flags_o, rx_d_o} !== '0 || level_o !== '0) begin
      failures++;
      $display("FAIL reset_data word=%h level=%0d need 0/0", {rx_flags_o, rx_d_o}, level_o);
    end
    checks++;
    if ({rts_n_o, overrun_o, break_o, timeout_o} !== 4'b1000) begin
      failures++;
      $display("FAIL reset_flags rts/ovr/brk/to=%b need 1000",
               {rts_n_o, overrun_o, break_o, timeout_o});
    end
    rst = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (rts_n_o !== 1'b0) begin
      failures++;
      $display("FAIL rts_after_reset rts_n=%b need 0", rts_n_o);
    end
  endtask

  task automatic test_basic_8n1();
    logic ok;
    logic [DATA_W+1:0] w;
    send_frame(9'h0A5, 8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    checks++;
    if (rx_d_valid_o !== 1'b1 || level_o !== LVL_W'(1)) begin
      failures++;
      $display("FAIL basic_valid valid=%b level=%0d need 1/1", rx_d_valid_o, level_o);
    end
    pop_word(ok, w);
    checks++;
    if (!ok || w !== {2'b00, 9'h0A5}) begin
      failures++;
      $display("FAIL basic_word got=%h ok=%b need %h", w, ok, {2'b00, 9'h0A5});
    end
    checks++;
    if (empty_o !== 1'b1) begin
      failures++;
      $display("FAIL basic_empty empty=%b need 1", empty_o);
    end
  endtask

  task automatic test_parity_7e1();
    logic ok;
    logic [DATA_W+1:0] w;
    send_frame(9'h041, 7, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    idle_bits(1);
    pop_word(ok, w);
    checks++;
    if (!ok || w !== {2'b01, 9'h041}) begin
      failures++;
      $display("FAIL parity_bad got=%h ok=%b need %h", w, ok, {2'b01, 9'h041});
    end
    send_frame(9'h041, 7, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    idle_bits(1);
    pop_word(ok, w);
    checks++;
    if (!ok || w !== {2'b00, 9'h041}) begin
      failures++;
      $display("FAIL parity_good got=%h ok=%b need %h", w, ok, {2'b00, 9'h041});
    end
  endtask

  task automatic test_glitch();
    logic ok;
    logic [DATA_W+1:0] w;
    rx_i = 1'b0;
    repeat (6) @(negedge clk);
    idle_bits(3);
    checks++;
    if (rx_d_valid_o !== 1'b0 || level_o !== '0) begin
      failures++;
      $display("FAIL glitch_nopush valid=%b level=%0d need 0/0", rx_d_valid_o, level_o);
    end
    send_frame(9'h03C, 8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    idle_bits(1);
    pop_word(ok, w);
    checks++;
    if (!ok || w !== {2'b00, 9'h03C}) begin
      failures++;
      $display("FAIL glitch_next got=%h ok=%b need %h", w, ok, {2'b00, 9'h03C});
    end
  endtask

  task automatic test_random();
    logic ok, pe, bs1;
    logic [DATA_W-1:0] d;
    logic [DATA_W+1:0] w, e;
    for (int f = 0; f < 24; f++) begin
      divider_i = DIV_W'($urandom_range(0, 2));
      bit_len   = OSR * (int'(divider_i) + 1);
      idle_bits(1);
      pe  = 1'($urandom);
      bs1 = ($urandom_range(0, 5) == 0);
      d   = DATA_W'($urandom);
      if (bs1) d[0] = 1'b1;
      send_frame(d, $urandom_range(3, 12), pe, 1'($urandom), 1'($urandom),
                 pe & ($urandom_range(0, 3) == 0), bs1, ($urandom_range(0, 4) == 0),
                 1'b1, 1'b1);
      idle_bits(2);
      pop_word(ok, w);
      e = exp_q.pop_front();
      checks++;
      if (!ok || w !== e) begin
        failures++;
        $display("FAIL random_frame%0d got=%h ok=%b need %h", f, w, ok, e);
      end
    end
    divider_i = '0;
    bit_len   = OSR;
    idle_bits(1);
  endtask

  task automatic test_overflow();
    logic ok;
    logic [DATA_W+1:0] w, e;
    for (int k = 1; k <= FIFO_DEPTH + 2; k++) begin
      send_frame(DATA_W'($urandom_range(1, 255)), 8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                 1'b0, 1'b1);
      idle_bits(1);
      checks++;
      if (level_o !== LVL_W'(exp_q.size()) ||
          rts_n_o !== (exp_q.size() >= FIFO_DEPTH - 2)) begin
        failures++;
        $display("FAIL fill%0d level=%0d rts_n=%b need %0d/%b", k, level_o, rts_n_o,
                 exp_q.size(), (exp_q.size() >= FIFO_DEPTH - 2));
      end
    end
    checks++;
    if (overrun_o !== exp_ovr || full_o !== 1'b1) begin
      failures++;
      $display("FAIL overrun_set ovr=%b full=%b need %b/1", overrun_o, full_o, exp_ovr);
    end
    pulse_clr();
    exp_ovr = 1'b0;
    checks++;
    if (overrun_o !== 1'b0) begin
      failures++;
      $display("FAIL overrun_clr ovr=%b need 0", overrun_o);
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      pop_word(ok, w);
      checks++;
      if (!ok || w !== e) begin
        failures++;
        $display("FAIL drain got=%h ok=%b need %h", w, ok, e);
      end
    end
  endtask

  task automatic test_break();
    logic ok;
    logic [DATA_W+1:0] w;
    rx_i = 1'b0;
    repeat (20 * bit_len) @(negedge clk);
    checks++;
    if (break_o !== 1'b1 || level_o !== '0) begin
      failures++;
      $display("FAIL break_set brk=%b level=%0d need 1/0", break_o, level_o);
    end
    idle_bits(2);
    send_frame(9'h055, 8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    idle_bits(1);
    pop_word(ok, w);
    checks++;
    if (!ok || w !== {2'b00, 9'h055}) begin
      failures++;
      $display("FAIL break_next got=%h ok=%b need %h", w, ok, {2'b00, 9'h055});
    end
    pulse_clr();
    checks++;
    if (break_o !== 1'b0) begin
      failures++;
      $display("FAIL break_clr brk=%b need 0", break_o);
    end
  endtask

  task automatic test_timeout();
    logic ok;
    logic [DATA_W+1:0] w;
    pulse_clr();
    send_frame(9'h05A, 8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    idle_bits(30);
    checks++;
    if (timeout_o !== 1'b0) begin
      failures++;
      $display("FAIL timeout_early to=%b need 0", timeout_o);
    end
    idle_bits(15);
    checks++;
    if (timeout_o !== 1'b1) begin
      failures++;
      $display("FAIL timeout_set to=%b need 1", timeout_o);
    end
    pop_word(ok, w);
    checks++;
    if (timeout_o !== 1'b0 || !ok || w !== {2'b00, 9'h05A}) begin
      failures++;
      $display("FAIL timeout_pop to=%b got=%h need 0/%h", timeout_o, w, {2'b00, 9'h05A});
    end
  endtask

  task automatic test_disable();
    logic ok;
    logic [DATA_W+1:0] w;
    send_frame(9'h011, 8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    idle_bits(1);
    drive_bit(1'b0);
    drive_bit(1'b0);
    drive_bit(1'b1);
    drive_bit(1'b0);
    enable_i = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (rts_n_o !== 1'b1) begin
      failures++;
      $display("FAIL disable_rts rts_n=%b need 1", rts_n_o);
    end
    idle_bits(2);
    enable_i = 1'b1;
    idle_bits(12);
    checks++;
    if (level_o !== LVL_W'(1)) begin
      failures++;
      $display("FAIL disable_drop level=%0d need 1", level_o);
    end
    pop_word(ok, w);
    checks++;
    if (!ok || w !== {2'b00, 9'h011}) begin
      failures++;
      $display("FAIL disable_kept got=%h ok=%b need %h", w, ok, {2'b00, 9'h011});
    end
  endtask

  task automatic test_reset_midframe();
    logic ok;
    logic [DATA_W+1:0] w;
    send_frame(9'h0C3, 8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    idle_bits(1);
    drive_bit(1'b0);
    drive_bit(1'b1);
    rst  = 1'b1;
    rx_i = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    idle_bits(12);
    checks++;
    if (level_o !== '0 || rx_d_valid_o !== 1'b0) begin
      failures++;
      $display("FAIL rst_mid level=%0d valid=%b need 0/0", level_o, rx_d_valid_o);
    end
    send_frame(9'h096, 8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    idle_bits(1);
    pop_word(ok, w);
    checks++;
    if (!ok || w !== {2'b00, 9'h096}) begin
      failures++;
      $display("FAIL rst_next got=%h ok=%b need %h", w, ok, {2'b00, 9'h096});
    end
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst          = 1'b1;
    rx_i         = 1'b1;
    enable_i     = 1'b1;
    divider_i    = '0;
    data_bits_i  = 4'd8;
    parity_en_i  = 1'b0;
    parity_odd_i = 1'b0;
    stop2_i      = 1'b0;
    rx_d_ready_i = 1'b0;
    err_clr_i    = 1'b0;
    test_reset();
    idle_bits(2);
    test_basic_8n1();
    test_parity_7e1();
    test_glitch();
    test_random();
    test_overflow();
    test_break();
    test_timeout();
    test_disable();
    test_reset_midframe();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
